// File: rtl/sgm_pkg.sv
// Shared constants and types for the SGM disparity post-processing blocks.
package sgm_pkg;

  localparam int unsigned PX_WIDTH_DEFAULT = 8;
  localparam int unsigned MEDIAN_LAT       = 5;

  typedef logic [PX_WIDTH_DEFAULT-1:0] pixel_t;

endpackage

// File: rtl/sort3.sv
// Registered three-input sorter: lo <= min, mid <= median, hi <= max.
module sort3 import sgm_pkg::*; #(
  parameter int unsigned W = PX_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] lo,
  output logic [W-1:0] mid,
  output logic [W-1:0] hi
);

  logic [W-1:0] s0, s1, s2, t;

  // Three compare-exchange steps order the inputs ascending.
  always_comb begin
    t  = '0;
    s0 = a;
    s1 = b;
    s2 = c;
    if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
    if (s1 > s2) begin t = s1; s1 = s2; s2 = t; end
    if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
  end

  // Register the sorted triple.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo  <= '0;
      mid <= '0;
      hi  <= '0;
    end else begin
      lo  <= s0;
      mid <= s1;
      hi  <= s2;
    end
  end

endmodule

// File: rtl/disparity_median.sv
// 3x3 median filter on the disparity stream; window centre is one row up and
// one column left of the newest pixel, fixed 5-cycle latency.
module disparity_median import sgm_pkg::*; #(
  parameter int unsigned IMG_W    = 200,
  parameter int unsigned PX_WIDTH = PX_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                de_in,
  input  logic                h_sync_in,
  input  logic                v_sync_in,
  input  logic [PX_WIDTH-1:0] pixel_in,
  output logic                clk_out,
  output logic                de_out,
  output logic                h_sync_out,
  output logic                v_sync_out,
  output logic [PX_WIDTH-1:0] pixel_out
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  logic [MEDIAN_LAT-1:0] de_sr, hs_sr, vs_sr;
  logic armed, de_eff, de_prev, vs_prev, de_fall, vs_rise;
  logic [CW-1:0] col;
  logic over;
  logic [1:0] row;

  logic [PX_WIDTH-1:0] line0 [0:IMG_W-1];
  logic [PX_WIDTH-1:0] line1 [0:IMG_W-1];
  logic [PX_WIDTH-1:0] rd0, rd1;

  logic s1_valid, s1_over, s1_byp;
  logic [PX_WIDTH-1:0] s1_px;

  logic [PX_WIDTH-1:0] w_top [3];
  logic [PX_WIDTH-1:0] w_mid [3];
  logic [PX_WIDTH-1:0] w_bot [3];
  logic byp2, byp3, byp4;
  logic [PX_WIDTH-1:0] ctr3, ctr4;

  logic [PX_WIDTH-1:0] c_lo [3];
  logic [PX_WIDTH-1:0] c_md [3];
  logic [PX_WIDTH-1:0] c_hi [3];
  logic [PX_WIDTH-1:0] max_lo, med_md, min_hi;
  logic [PX_WIDTH-1:0] mins_unused_lo, mins_unused_md;
  logic [PX_WIDTH-1:0] meds_unused_lo, meds_unused_hi;
  logic [PX_WIDTH-1:0] maxs_unused_md, maxs_unused_hi;
  logic [PX_WIDTH-1:0] lo_ab, hi_ab, hi_abc, med9;

  assign clk_out = clk;

  // A line cut by reset is ignored until de_in has been seen low once.
  assign de_eff  = de_in & armed;
  assign de_fall = de_prev & ~de_eff;
  assign vs_rise = v_sync_in & ~vs_prev;

  // Sync delay lines matching the pixel pipeline depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr <= {de_sr[MEDIAN_LAT-2:0], de_in};
      hs_sr <= {hs_sr[MEDIAN_LAT-2:0], h_sync_in};
      vs_sr <= {vs_sr[MEDIAN_LAT-2:0], v_sync_in};
    end
  end

  assign de_out     = de_sr[MEDIAN_LAT-1];
  assign h_sync_out = hs_sr[MEDIAN_LAT-1];
  assign v_sync_out = vs_sr[MEDIAN_LAT-1];

  // Column/row tracking; col saturates and 'over' marks pixels beyond IMG_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      de_prev <= 1'b0;
      vs_prev <= 1'b0;
      col     <= '0;
      over    <= 1'b0;
      row     <= '0;
    end else begin
      if (!de_in) armed <= 1'b1;
      de_prev <= de_eff;
      vs_prev <= v_sync_in;
      if (de_eff) begin
        if (col == COL_LAST) over <= 1'b1;
        else                 col  <= col + CW'(1);
      end else if (de_fall) begin
        col  <= '0;
        over <= 1'b0;
      end
      if (vs_rise)                      row <= '0;
      else if (de_fall && row != 2'd2)  row <= row + 2'd1;
    end
  end

  // Two line buffers, read-before-write: line0 ages into line1 at the same address.
  always_ff @(posedge clk) begin
    rd0 <= line0[col];
    rd1 <= line1[col];
    if (de_eff && !over) begin
      line0[col] <= pixel_in;
      line1[col] <= line0[col];
    end
  end

  // Stage 1: newest pixel and its border/overflow status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_over  <= 1'b0;
      s1_byp   <= 1'b0;
      s1_px    <= '0;
    end else begin
      s1_valid <= de_eff;
      s1_over  <= over;
      s1_byp   <= (row < 2'd2) || (col < CW'(2)) || over;
      s1_px    <= pixel_in;
    end
  end

  // Stage 2: 3x3 window shifts once per valid pixel; overflow pixels carry
  // their own value as the whole column since nothing is buffered above them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_top <= '{default: '0};
      w_mid <= '{default: '0};
      w_bot <= '{default: '0};
      byp2  <= 1'b0;
    end else begin
      byp2 <= s1_byp;
      if (s1_valid) begin
        w_top[2] <= w_top[1];
        w_mid[2] <= w_mid[1];
        w_bot[2] <= w_bot[1];
        w_top[1] <= w_top[0];
        w_mid[1] <= w_mid[0];
        w_bot[1] <= w_bot[0];
        w_top[0] <= s1_over ? s1_px : rd1;
        w_mid[0] <= s1_over ? s1_px : rd0;
        w_bot[0] <= s1_px;
      end
    end
  end

  // Stage 3: sort each window column.
  for (genvar i = 0; i < 3; i++) begin : g_col_sort
    sort3 #(.W(PX_WIDTH)) u_sort (
      .clk(clk), .rst(rst),
      .a(w_top[i]), .b(w_mid[i]), .c(w_bot[i]),
      .lo(c_lo[i]), .mid(c_md[i]), .hi(c_hi[i])
    );
  end

  // Stage 4: max of mins, median of medians, min of maxes.
  sort3 #(.W(PX_WIDTH)) u_mins (
    .clk(clk), .rst(rst), .a(c_lo[0]), .b(c_lo[1]), .c(c_lo[2]),
    .lo(mins_unused_lo), .mid(mins_unused_md), .hi(max_lo)
  );
  sort3 #(.W(PX_WIDTH)) u_meds (
    .clk(clk), .rst(rst), .a(c_md[0]), .b(c_md[1]), .c(c_md[2]),
    .lo(meds_unused_lo), .mid(med_md), .hi(meds_unused_hi)
  );
  sort3 #(.W(PX_WIDTH)) u_maxs (
    .clk(clk), .rst(rst), .a(c_hi[0]), .b(c_hi[1]), .c(c_hi[2]),
    .lo(min_hi), .mid(maxs_unused_md), .hi(maxs_unused_hi)
  );

  // Centre value and bypass flag travel alongside the sort stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp3 <= 1'b0;
      byp4 <= 1'b0;
      ctr3 <= '0;
      ctr4 <= '0;
    end else begin
      byp3 <= byp2;
      byp4 <= byp3;
      ctr3 <= w_mid[1];
      ctr4 <= ctr3;
    end
  end

  // Median of the three stage-4 candidates.
  always_comb begin
    lo_ab  = (max_lo < med_md) ? max_lo : med_md;
    hi_ab  = (max_lo < med_md) ? med_md : max_lo;
    hi_abc = (hi_ab < min_hi) ? hi_ab : min_hi;
    med9   = (lo_ab > hi_abc) ? lo_ab : hi_abc;
  end

  // Stage 5: select filtered or centre value, blank outside active video.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out <= '0;
    end else if (!de_sr[MEDIAN_LAT-2]) begin
      pixel_out <= '0;
    end else begin
      pixel_out <= byp4 ? ctr4 : med9;
    end
  end

endmodule

// File: tb/tb_disparity_median.sv
// Randomised bench for disparity_median against a frame-level reference model.
module tb_disparity_median;
  import sgm_pkg::*;

  localparam int unsigned IMG_W = 200;

  logic   clk = 1'b0;
  logic   rst, de_in, h_sync_in, v_sync_in;
  pixel_t pixel_in;
  logic   clk_out, de_out, h_sync_out, v_sync_out;
  pixel_t pixel_out;

  always #5 clk = ~clk;

  disparity_median #(.IMG_W(IMG_W), .PX_WIDTH(PX_WIDTH_DEFAULT)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in), .pixel_in(pixel_in), .clk_out(clk_out),
    .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .pixel_out(pixel_out)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lines as arrays, window as the last three valid columns.
  typedef struct { int unsigned t, m, b; bit k; } col_t;
  typedef struct { bit de, hs, vs, k; int unsigned px; } exp_t;

  int unsigned lb0 [IMG_W];
  int unsigned lb1 [IMG_W];
  bit          k0  [IMG_W];
  bit          k1  [IMG_W];
  col_t        prev0, prev1;
  exp_t        ring [8];
  int unsigned nsteps, lines_done, pidx;
  bit          prev_valid, prev_vs, armed;

  function automatic int unsigned median9(input col_t a, input col_t b, input col_t c);
    int unsigned q[$];
    q = '{a.t, a.m, a.b, b.t, b.m, b.b, c.t, c.m, c.b};
    q.sort();
    return q[4];
  endfunction

  task automatic model_reset();
    prev0 = '{t: 0, m: 0, b: 0, k: 1'b1};
    prev1 = prev0;
    for (int i = 0; i < 8; i++) ring[i] = '{default: 0};
    nsteps = 0; lines_done = 0; pidx = 0;
    prev_valid = 0; prev_vs = 0; armed = 0;
  endtask

  task automatic model_edge(input bit de, input bit hs, input bit vs, input int unsigned px);
    exp_t e;
    col_t c;
    bit valid, fall, byp;
    valid = de && armed;
    fall  = prev_valid && !valid;
    e = '{de: de, hs: hs, vs: vs, k: 1'b1, px: 0};
    if (valid) begin
      if (pidx < IMG_W) begin
        c = '{t: lb1[pidx], m: lb0[pidx], b: px, k: k1[pidx] && k0[pidx]};
        lb1[pidx] = lb0[pidx]; k1[pidx] = k0[pidx];
        lb0[pidx] = px;        k0[pidx] = 1'b1;
      end else begin
        c = '{t: px, m: px, b: px, k: 1'b1};
      end
      byp = (lines_done < 2) || (pidx < 2) || (pidx >= IMG_W);
      if (byp) begin
        e.px = prev0.m; e.k = prev0.k;
      end else begin
        e.px = median9(c, prev0, prev1); e.k = c.k && prev0.k && prev1.k;
      end
      prev1 = prev0; prev0 = c;
      pidx++;
    end
    if (!de) armed = 1;
    if (vs && !prev_vs)             lines_done = 0;
    else if (fall && lines_done < 2) lines_done++;
    if (fall) pidx = 0;
    prev_valid = valid;
    prev_vs    = vs;
    ring[nsteps % 8] = e;
    nsteps++;
  endtask

  task automatic check_outputs();
    exp_t e;
    if (nsteps >= 5) e = ring[(nsteps - 5) % 8];
    else             e = '{default: 0};
    chk("de_out", de_out, e.de);
    chk("h_sync_out", h_sync_out, e.hs);
    chk("v_sync_out", v_sync_out, e.vs);
    chk("clk_out", clk_out, clk);
    if (!e.de)     chk("pixel_idle", pixel_out, 0);
    else if (e.k)  chk("pixel", pixel_out, e.px);
  endtask

  task automatic step(input bit de, input bit hs, input bit vs, input int unsigned px);
    de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = pixel_t'(px);
    @(posedge clk); #1;
    model_edge(de, hs, vs, px);
    check_outputs();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_de"}, de_out, 0);
    chk({tag, "_hs"}, h_sync_out, 0);
    chk({tag, "_vs"}, v_sync_out, 0);
    chk({tag, "_px"}, pixel_out, 0);
  endtask

  task automatic do_reset();
    rst = 1; de_in = 0; h_sync_in = 0; v_sync_in = 0; pixel_in = '0;
    #2;
    check_zero("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst = 0;
    model_reset();
  endtask

  function automatic int unsigned gen(input int kind, input int unsigned r, input int unsigned c);
    case (kind)
      0:       return 'h40;
      1:       return (r == 5 && c == 5) ? 'hFF : 'h10;
      2:       return (r < 2) ? c % 256 : 'h80;
      3:       return c % 256;
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  task automatic hblank();
    for (int i = 0; i < 6; i++) step(0, i < 2, 0, 0);
  endtask

  task automatic line(input int kind, input int unsigned r, input int unsigned width);
    hblank();
    for (int unsigned c = 0; c < width; c++) step(1, 0, 0, gen(kind, r, c));
  endtask

  task automatic vblank();
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
  endtask

  task automatic frame(input int kind, input int unsigned nlines, input int wide_row);
    vblank();
    for (int unsigned r = 0; r < nlines; r++)
      line(kind, r, (int'(r) == wide_row) ? IMG_W + 10 : IMG_W);
  endtask

  initial begin
    model_reset();
    do_reset();
    frame(0, 10, -1);
    frame(1, 10, -1);
    frame(2, 6, -1);
    frame(3, 6, -1);
    frame(4, 6, 3);
    // Reset in the middle of line 4 at col 50, then four lines without vsync.
    vblank();
    for (int unsigned r = 0; r < 4; r++) line(4, r, IMG_W);
    hblank();
    for (int unsigned c = 0; c < 50; c++) step(1, 0, 0, gen(4, 4, c));
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int unsigned r = 0; r < 4; r++) line(4, r, IMG_W);
    frame(4, 4, -1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
